// File: rtl/reaction_timer_core.sv
// Multi-player reaction timer: random hold-off, GO lamp, millisecond BCD race,
// false-start detection and a clearable best-time register.
module reaction_timer_core #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int DIGITS       = 4,
  parameter int PLAYERS      = 2,
  parameter int LFSR_W       = 11,
  parameter int MIN_DELAY_MS = 500
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PLAYERS-1:0]    react,
  input  logic                  clear_hs,
  output logic                  go_led,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd_time,
  output logic [4*DIGITS-1:0]   bcd_best,
  output logic [2:0]            winner,
  output logic                  winner_valid,
  output logic                  false_start,
  output logic                  new_best
);

  localparam int PS_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DLY_SUM = MIN_DELAY_MS + (1 << LFSR_W);
  localparam int DLY_W   = ($clog2(DLY_SUM + 1) > LFSR_W + 1) ? $clog2(DLY_SUM + 1) : LFSR_W + 1;
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_GO, S_DONE, S_FOUL} state_t;

  state_t               state, state_nx;
  logic                 start_q;
  logic [PLAYERS-1:0]   react_q;
  logic                 start_edge;
  logic [PLAYERS-1:0]   react_edge;
  logic                 any_react;
  logic [2:0]           win_idx;
  logic [LFSR_W-1:0]    lfsr;
  logic [PS_W-1:0]      presc;
  logic                 tick;
  logic                 presc_clr;
  logic [DLY_W-1:0]     delay_ms;
  logic                 expire;
  logic [4*DIGITS-1:0]  bcd_inc;
  logic [DIGITS:0]      carry;
  logic                 all_nines;

  // ---------------- input edge detection ----------------
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      react_q <= '0;
    end else begin
      start_q <= start;
      react_q <= react;
    end
  end

  assign start_edge = start & ~start_q;
  assign react_edge = react & ~react_q;
  assign any_react  = |react_edge;

  // Lowest index wins when several players press in the same cycle.
  always_comb begin
    win_idx = '0;
    for (int i = PLAYERS - 1; i >= 0; i--)
      if (react_edge[i]) win_idx = 3'(i);
  end

  // ---------------- free-running LFSR (x^11 + x^9 + 1) ----------------
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) lfsr <= LFSR_W'(1);
    else     lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-3]};
  end

  // ---------------- millisecond prescaler ----------------
  // Restarting on WAIT/GO entry makes the first tick land exactly one ms later.
  assign presc_clr = (state_nx != state) && (state_nx == S_WAIT || state_nx == S_GO);
  assign tick      = (presc == PS_W'(CLKS_PER_MS - 1));

  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst)                    presc <= '0;
    else if (presc_clr || tick) presc <= '0;
    else                        presc <= presc + PS_W'(1);
  end

  // ---------------- BCD incrementer, ripple carry per digit ----------------
  assign carry[0] = 1'b1;
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [3:0] dig;
    assign dig                = bcd_time[4*d +: 4];
    assign carry[d+1]         = carry[d] & (dig == 4'd9);
    assign bcd_inc[4*d +: 4]  = carry[d] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
  end
  assign all_nines = carry[DIGITS];

  assign expire = tick && (delay_ms <= DLY_W'(1));

  // ---------------- FSM ----------------
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_edge) state_nx = S_ARM;
      S_ARM:  state_nx = S_WAIT;
      S_WAIT: begin
        if (any_react)   state_nx = S_FOUL;   // press beats expiry
        else if (expire) state_nx = S_GO;
      end
      S_GO: begin
        if (any_react)              state_nx = S_DONE;
        else if (tick && all_nines) state_nx = S_DONE;
      end
      S_DONE, S_FOUL: if (start_edge) state_nx = S_ARM;
      default: state_nx = S_IDLE;
    endcase
  end

  assign go_led      = (state == S_GO);
  assign busy        = (state == S_ARM) || (state == S_WAIT) || (state == S_GO);
  assign false_start = (state == S_FOUL);

  // ---------------- round datapath ----------------
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      delay_ms     <= '0;
      bcd_time     <= '0;
      bcd_best     <= ALL_NINES;
      winner       <= '0;
      winner_valid <= 1'b0;
      new_best     <= 1'b0;
    end else begin
      new_best <= 1'b0;
      case (state)
        S_ARM: begin
          delay_ms     <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr);
          bcd_time     <= '0;
          winner_valid <= 1'b0;
        end
        S_WAIT: begin
          if (any_react) winner   <= win_idx;
          else if (tick) delay_ms <= delay_ms - DLY_W'(1);
        end
        S_GO: begin
          if (any_react) begin
            winner       <= win_idx;
            winner_valid <= 1'b1;
            if (bcd_time < bcd_best) begin
              bcd_best <= bcd_time;
              new_best <= 1'b1;
            end
          end else if (tick && !all_nines) begin
            bcd_time <= bcd_inc;
          end
        end
        default: ;
      endcase
      // A clear in the same cycle as a record overrides it.
      if (clear_hs) begin
        bcd_best <= ALL_NINES;
        new_best <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reaction_timer_core.sv
// Self-checking bench for reaction_timer_core: directed rounds plus randomized
// rounds scored against a cycle-count model of hold-off, race time and best time.
module tb_reaction_timer_core;
  localparam int CPM    = 4;
  localparam int MIN_MS = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, clear_hs, start2, clear2;
  logic [1:0]  react, react2;
  logic        go_led, busy, winner_valid, false_start, new_best;
  logic [15:0] bcd_time, bcd_best;
  logic [2:0]  winner;
  logic        go2, busy2, wv2, fs2, nb2;
  logic [7:0]  time2, best2;
  logic [2:0]  win2;

  int n_tests = 0;
  int n_fail  = 0;
  int best_ms = 9999;
  int nb_cnt  = 0;
  logic [10:0] m_lfsr;

  reaction_timer_core #(.CLKS_PER_MS(CPM), .DIGITS(4), .PLAYERS(2), .LFSR_W(11),
                        .MIN_DELAY_MS(MIN_MS)) u1 (
    .MAX10_CLK1_50(clk), .rst(rst), .start(start), .react(react), .clear_hs(clear_hs),
    .go_led(go_led), .busy(busy), .bcd_time(bcd_time), .bcd_best(bcd_best),
    .winner(winner), .winner_valid(winner_valid), .false_start(false_start),
    .new_best(new_best));

  reaction_timer_core #(.CLKS_PER_MS(CPM), .DIGITS(2), .PLAYERS(2), .LFSR_W(11),
                        .MIN_DELAY_MS(MIN_MS)) u2 (
    .MAX10_CLK1_50(clk), .rst(rst), .start(start2), .react(react2), .clear_hs(clear2),
    .go_led(go2), .busy(busy2), .bcd_time(time2), .bcd_best(best2),
    .winner(win2), .winner_valid(wv2), .false_start(fs2), .new_best(nb2));

  function automatic logic [10:0] nx(input logic [10:0] v);
    return {v[9:0], v[10] ^ v[8]};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] lowest(input logic [1:0] m);
    for (int i = 0; i < 2; i++) if (m[i]) return 3'(i);
    return 3'd0;
  endfunction

  // Reference sequence of the random source, in lockstep with the DUT clock.
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 11'd1;
    else     m_lfsr <= nx(m_lfsr);

  always @(negedge clk) if (new_best === 1'b1) nb_cnt <= nb_cnt + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts a round when the loaded random value will be `want` (or any small
  // value when want<0). Returns in the ARM cycle with the expected hold-off.
  task automatic arm_round(input bit dut2, input int want, output int dly);
    int guard;
    guard = 0;
    while ((want >= 0) ? (nx(m_lfsr) != 11'(want)) : (nx(m_lfsr) > 11'd150)) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 4100) begin
        n_tests++; n_fail++;
        $display("FAIL arm_wait lfsr=%0d target=%0d not reached", m_lfsr, want);
        break;
      end
    end
    if (dut2) start2 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    start2 = 1'b0;
    dly = MIN_MS + int'(m_lfsr);
  endtask

  // Caller sits just after the GO entry edge; the press is seen p edges later.
  task automatic go_round(input logic [1:0] mask, input int p, input bit clr);
    int ms, nb0;
    bit upd;
    ms  = (p - 1) / CPM;
    upd = !clr && (ms < best_ms);
    if (clr) best_ms = 9999;
    else if (upd) best_ms = ms;
    if (p > 1) cyc(p - 1);
    nb0 = nb_cnt;
    react = mask;
    clear_hs = clr;
    @(posedge clk); #1;
    react = 2'b00;
    clear_hs = 1'b0;
    n_tests++;
    if ({go_led, busy, winner_valid} !== 3'b001) begin
      n_fail++; $display("FAIL done_flags got go/busy/wv=%b exp=001", {go_led, busy, winner_valid});
    end
    n_tests++;
    if (winner !== lowest(mask)) begin
      n_fail++; $display("FAIL done_winner got=%0d exp=%0d", winner, lowest(mask));
    end
    n_tests++;
    if (bcd_time !== to_bcd(ms)) begin
      n_fail++; $display("FAIL done_time got=%h exp=%h", bcd_time, to_bcd(ms));
    end
    n_tests++;
    if (bcd_best !== to_bcd(best_ms)) begin
      n_fail++; $display("FAIL done_best got=%h exp=%h", bcd_best, to_bcd(best_ms));
    end
    n_tests++;
    if (new_best !== upd) begin
      n_fail++; $display("FAIL new_best_pulse got=%b exp=%b", new_best, upd);
    end
    cyc(1);
    n_tests++;
    if (new_best !== 1'b0 || (nb_cnt - nb0) !== int'(upd)) begin
      n_fail++; $display("FAIL new_best_count got=%0d exp=%0d", nb_cnt - nb0, int'(upd));
    end
  endtask

  // Caller sits in the ARM cycle; the press is seen q edges into WAIT.
  task automatic foul_round(input logic [1:0] mask, input int q);
    int saw;
    saw = 0;
    for (int i = 0; i < q; i++) begin
      @(posedge clk); #1;
      if (go_led) saw++;
    end
    react = mask;
    @(posedge clk); #1;
    react = 2'b00;
    n_tests++;
    if ({false_start, go_led, busy, winner_valid} !== 4'b1000 || saw != 0) begin
      n_fail++; $display("FAIL foul_flags got fs/go/busy/wv=%b go_seen=%0d exp=1000/0",
                         {false_start, go_led, busy, winner_valid}, saw);
    end
    n_tests++;
    if (winner !== lowest(mask)) begin
      n_fail++; $display("FAIL foul_winner got=%0d exp=%0d", winner, lowest(mask));
    end
    n_tests++;
    if (bcd_best !== to_bcd(best_ms)) begin
      n_fail++; $display("FAIL foul_best got=%h exp=%h", bcd_best, to_bcd(best_ms));
    end
    cyc(8);
    n_tests++;
    if ({false_start, go_led} !== 2'b10) begin
      n_fail++; $display("FAIL foul_hold got fs/go=%b exp=10", {false_start, go_led});
    end
  endtask

  task automatic wait_go(input int dly);
    cyc(1 + CPM * dly);
    n_tests++;
    if (go_led !== 1'b1) begin
      n_fail++; $display("FAIL go_rise got=%b exp=1 after %0d ms", go_led, dly);
    end
  endtask

  task automatic test_reset;
    int seen;
    rst = 1'b1; start = 0; start2 = 0; react = 0; react2 = 0; clear_hs = 0; clear2 = 0;
    #23 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (busy | go_led | new_best | false_start | winner_valid) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL reset_idle got=%0d active cycles exp=0", seen);
    end
    n_tests++;
    if (bcd_time !== 16'h0000) begin
      n_fail++; $display("FAIL reset_time got=%h exp=0000", bcd_time);
    end
    n_tests++;
    if (bcd_best !== 16'h9999) begin
      n_fail++; $display("FAIL reset_best got=%h exp=9999", bcd_best);
    end
    n_tests++;
    if (winner !== 3'd0) begin
      n_fail++; $display("FAIL reset_winner got=%0d exp=0", winner);
    end
  endtask

  task automatic test_go_timing;
    int dly;
    arm_round(1'b0, 10, dly);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL arm_busy got=%b exp=1", busy);
    end
    cyc(60);
    n_tests++;
    if (go_led !== 1'b0) begin
      n_fail++; $display("FAIL go_early got=%b exp=0", go_led);
    end
    cyc(1);
    n_tests++;
    if (go_led !== 1'b1) begin
      n_fail++; $display("FAIL go_exact got=%b exp=1", go_led);
    end
    go_round(2'b10, 149, 1'b0);
  endtask

  task automatic test_foul;
    int dly;
    arm_round(1'b0, -1, dly);
    foul_round(2'b01, 3);
  endtask

  task automatic test_simultaneous;
    int dly;
    arm_round(1'b0, -1, dly);
    wait_go(dly);
    go_round(2'b11, 161, 1'b0);
  endtask

  task automatic test_tick_collision;
    int dly;
    arm_round(1'b0, -1, dly);
    wait_go(dly);
    go_round(2'b01, 148, 1'b0);
    arm_round(1'b0, -1, dly);
    wait_go(dly);
    go_round(2'b10, 145, 1'b0);
  endtask

  task automatic test_random;
    int dly, q;
    logic [1:0] mask;
    for (int r = 0; r < 6; r++) begin
      arm_round(1'b0, -1, dly);
      mask = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) begin
        q = ($urandom_range(0, 1) == 0) ? CPM * dly : $urandom_range(1, CPM * dly);
        foul_round(mask, q);
      end else begin
        wait_go(dly);
        go_round(mask, $urandom_range(21, 300), 1'b0);
      end
    end
  endtask

  task automatic test_rst_mid;
    int dly;
    arm_round(1'b0, -1, dly);
    wait_go(dly);
    cyc(7);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({go_led, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rst_async got go/busy=%b exp=00", {go_led, busy});
    end
    n_tests++;
    if (bcd_best !== 16'h9999 || bcd_time !== 16'h0000) begin
      n_fail++; $display("FAIL rst_regs got best=%h time=%h exp=9999/0000", bcd_best, bcd_time);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    best_ms = 9999;
    cyc(3);
    n_tests++;
    if ({busy, go_led, false_start} !== 3'b000) begin
      n_fail++; $display("FAIL rst_idle got busy/go/fs=%b exp=000", {busy, go_led, false_start});
    end
  endtask

  task automatic test_clear;
    int dly;
    arm_round(1'b0, -1, dly);
    wait_go(dly);
    go_round(2'b10, 5, 1'b1);
  endtask

  task automatic test_timeout;
    int dly;
    arm_round(1'b1, 10, dly);
    cyc(1 + CPM * dly);
    n_tests++;
    if (go2 !== 1'b1) begin
      n_fail++; $display("FAIL to_go got=%b exp=1", go2);
    end
    cyc(399);
    n_tests++;
    if (go2 !== 1'b1 || time2 !== 8'h99) begin
      n_fail++; $display("FAIL to_before got go=%b time=%h exp=1/99", go2, time2);
    end
    cyc(1);
    n_tests++;
    if ({go2, busy2, wv2, fs2} !== 4'b0000 || time2 !== 8'h99) begin
      n_fail++; $display("FAIL to_done got go/busy/wv/fs=%b time=%h exp=0000/99",
                         {go2, busy2, wv2, fs2}, time2);
    end
    n_tests++;
    if (best2 !== 8'h99) begin
      n_fail++; $display("FAIL to_best got=%h exp=99", best2);
    end
  endtask

  initial begin
    test_reset;
    test_go_timing;
    test_foul;
    test_simultaneous;
    test_tick_collision;
    test_random;
    test_rst_mid;
    test_clear;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Parametrised multi-player reaction-timer engine: random hold-off, then a GO lamp, then a millisecond BCD race between PLAYERS buttons. Reports winner, elapsed time, false starts and a resettable best-time register. Sits between the board I/O top level (keys/switches/LEDs) and the seven-segment BCD decoders. Replaces the separate state machine, downcounter, LFSR and BCD counter with a single block.

Parameters:
CLKS_PER_MS, 50000, clock cycles per 1 ms tick (prescaler terminal count +1)
DIGITS, 4, BCD digits of elapsed/best time (max 10^DIGITS-1 ms)
PLAYERS, 2, number of react inputs (1..8)
LFSR_W, 11, random-delay LFSR width (11 only supported tap set: x^11+x^9+1)
MIN_DELAY_MS, 500, fixed ms added to LFSR value for hold-off

Ports:
MAX10_CLK1_50  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  level, already synchronised; rising edge starts a round
react  in  PLAYERS  levels, already synchronised; rising edge = press
clear_hs  in  1  synchronous clear of best time (any state)
go_led  out  1  high while timing (GO state)
busy  out  1  high in ARM/WAIT/GO
bcd_time  out  4*DIGITS  elapsed ms, nibble 0 = units
bcd_best  out  4*DIGITS  best time, nibble 0 = units
winner  out  3  index of first player to react (or fouling player)
winner_valid  out  1  high in DONE when a player reacted
false_start  out  1  high in FOUL
new_best  out  1  one-cycle pulse when bcd_best updated

Behaviour:
- Reset (async): state IDLE; go_led=0, busy=0, bcd_time=0, bcd_best=all 9s, winner=0, winner_valid=0, false_start=0, new_best=0; LFSR=1; prescaler=0; edge-detect registers=0.
- Edge detection: start and react registered once; edge = in & ~prev. All transitions use edges only; held buttons do not retrigger.
- LFSR: free-running every clock, never reset except by rst, never all-zero.
- ms tick: prescaler counts 0..CLKS_PER_MS-1; tick is one-cycle at terminal count; prescaler cleared on entry to WAIT and GO, so the first tick arrives exactly CLKS_PER_MS cycles after entry.
- States:
  IDLE: wait start edge -> ARM.
  ARM (1 cycle): delay_ms <= MIN_DELAY_MS + LFSR value (binary, width LFSR_W+1 minimum); bcd_time cleared; winner_valid/false_start cleared -> WAIT.
  WAIT: delay_ms decremented per tick; any react edge -> FOUL, winner = lowest index pressing; reaching 0 on a tick -> GO.
  GO: go_led=1; bcd_time BCD-increments per tick with per-digit carry 9->0; any react edge -> DONE, winner = lowest index, winner_valid=1; a tick when bcd_time is all 9s -> DONE with winner_valid=0 (timeout, bcd_time held at all 9s).
  DONE/FOUL: outputs held; start edge -> ARM (new round); no other exit.
- Simultaneous: multiple react edges same cycle -> lowest index wins. React edge and tick same cycle in WAIT -> FOUL (press beats expiry). React edge and tick same cycle in GO -> DONE with bcd_time not incremented.
- Best time: on GO->DONE with winner_valid, if bcd_time < bcd_best (unsigned compare of packed nibbles) then bcd_best <= bcd_time and new_best pulses the cycle after transition. Equal time: no update. clear_hs sets bcd_best to all 9s; clear_hs same cycle as an update: clear wins.
- start edge while busy: ignored.
- rst mid-round: immediate return to reset values, best time lost.

Test Plan:
- Reset then idle 1000 cycles (CLKS_PER_MS=4 in bench) -> all outputs at reset values, bcd_best=16'h9999.
- LFSR forced value 10 via known cycle count, MIN_DELAY_MS=5: start edge -> go_led rises exactly 1+1+15*4 cycles after edge; react[1] after 37 ticks -> bcd_time=16'h0037, winner=1, winner_valid=1, bcd_best=16'h0037, new_best one pulse.
- React[0] during WAIT -> FOUL, false_start=1, winner=0, go_led never rises, bcd_best unchanged.
- react[0] and react[1] same cycle in GO -> winner=0; second round 40 ms -> bcd_best stays 16'h0037, no new_best.
- No react, DIGITS=2: bcd_time stops at 8'h99, DONE with winner_valid=0, busy=0.
- clear_hs asserted with a pending better time -> bcd_best=all 9s; rst asserted in GO -> go_led low asynchronously, state IDLE.
